// File: rtl/bus_mem_pkg.sv
// rtl/bus_mem_pkg.sv - shared FSM encoding and width helpers for bus_mem
package bus_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter must hold WAIT itself, so size for WAIT+1 values.
  function automatic int cnt_w(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

  function automatic int idx_w(input int nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/bus_mem_rr_arbiter.sv
// rtl/bus_mem_rr_arbiter.sv - round-robin arbiter, search starts after the last grant
module rr_arbiter
  import bus_mem_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last,
  input  logic           en,
  output logic [NCH-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(last) + i) % NCH;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_mem.sv
// rtl/bus_mem.sv - multi-channel wait-state memory; BUS_MEM_OOR_ERR_EN enables the err flag
module bus_mem
  import bus_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int NCH    = 2,
  parameter int WAIT   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        req,
  input  logic [NCH-1:0]        we,
  input  logic [NCH*ADDR_W-1:0] addr,
  input  logic [NCH*DATA_W-1:0] wdata,
  output logic [NCH-1:0]        ready,
  output logic [NCH-1:0]        gnt,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  busy
);

  localparam int CW     = cnt_w(WAIT);
  localparam int IW     = idx_w(NCH);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       last_q, sel_idx;
  logic [NCH-1:0]      gnt_q, ready_q, arb_gnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q, mem_rd;
  logic                access, in_range;
  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .req (req),
    .last(last_q),
    .en  (state_q == S_IDLE),
    .gnt (arb_gnt)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NCH; i++)
      if (arb_gnt[i]) sel_idx = IW'(i);
  end

  assign access   = (state_q == S_WAIT) && (cnt_q == '0);
  assign in_range = {1'b0, addr_q} < DEPTH_L;
  assign mem_rd   = mem[addr_q[MEM_AW-1:0]];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req) state_d = S_WAIT;
      S_WAIT:  if (access) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(NCH - 1);
      gnt_q   <= '0;
      ready_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (|req) begin
          gnt_q   <= arb_gnt;
          last_q  <= sel_idx;
          we_q    <= we[sel_idx];
          addr_q  <= addr[sel_idx*ADDR_W +: ADDR_W];
          wdata_q <= wdata[sel_idx*DATA_W +: DATA_W];
          cnt_q   <= CW'(WAIT);
        end
        S_WAIT: if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          ready_q <= gnt_q;
          if (!we_q) rdata_q <= in_range ? mem_rd : '0;
        end
        S_DONE: begin
          ready_q <= '0;
          gnt_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (access && we_q && in_range) mem[addr_q[MEM_AW-1:0]] <= wdata_q;
  end

`ifdef BUS_MEM_OOR_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_q <= 1'b0;
    else if (access)             err_q <= ~in_range;
    else if (state_q == S_DONE)  err_q <= 1'b0;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ready = ready_q;
  assign gnt   = gnt_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE);

endmodule
